// File: rtl/even_pipe_pkg.sv
// Shared types for the result-staging pipe: pipe entry, unit encoding and
// helpers for per-unit latency lookup.
package even_pipe_pkg;
  localparam int PKG_W     = 128;
  localparam int PKG_AW    = 7;
  localparam int PKG_DEPTH = 7;
  localparam int STG_W     = $clog2(PKG_DEPTH + 1);

  typedef enum logic [1:0] {FP = 2'd0, FX2 = 2'd1, BYTE = 2'd2, FX1 = 2'd3} unit_e;

  typedef struct packed {
    logic              valid;
    logic              killed;
    logic              write;
    unit_e             unit;
    logic [PKG_AW-1:0] addr;
    logic              ready;
    logic [PKG_W-1:0]  data;
  } entry_t;

  // LAT is written as a concatenation with unit 0 leftmost, so unit u lives
  // in the nibble counted from the top.
  function automatic logic [3:0] lat_of(input logic [63:0] lat, input int u, input int n);
    return lat[(n-1-u)*4 +: 4];
  endfunction
endpackage

// File: rtl/even_result_pipe_if.sv
// Issue / operand / result / writeback bundle of the result-staging pipe.
interface even_result_pipe_if #(
  parameter int W         = 128,
  parameter int AW        = 7,
  parameter int NUM_UNITS = 4,
  parameter int NSRC      = 3
);
  logic                          iss_valid;
  logic [$clog2(NUM_UNITS)-1:0]  iss_unit;
  logic [AW-1:0]                 iss_rt_addr;
  logic                          iss_reg_write;
  logic [NSRC-1:0]               src_valid;
  logic [NSRC-1:0][AW-1:0]       src_addr;
  logic [NUM_UNITS-1:0]          res_valid;
  logic [NUM_UNITS-1:0][W-1:0]   res_data;
  logic                          flush;
  logic                          stall;
  logic [NSRC-1:0]               fwd_hit;
  logic [NSRC-1:0][W-1:0]        fwd_data;
  logic                          wb_valid;
  logic [AW-1:0]                 wb_addr;
  logic [W-1:0]                  wb_data;
  logic                          err_orphan;
  logic                          err_missing;
  logic [31:0]                   stall_cnt;

  modport master (
    output iss_valid, iss_unit, iss_rt_addr, iss_reg_write, src_valid, src_addr,
           res_valid, res_data, flush,
    input  stall, fwd_hit, fwd_data, wb_valid, wb_addr, wb_data, err_orphan,
           err_missing, stall_cnt
  );
  modport slave (
    input  iss_valid, iss_unit, iss_rt_addr, iss_reg_write, src_valid, src_addr,
           res_valid, res_data, flush,
    output stall, fwd_hit, fwd_data, wb_valid, wb_addr, wb_data, err_orphan,
           err_missing, stall_cnt
  );
endinterface

// File: rtl/fwd_match.sv
// Youngest-first producer search for one source operand; reports a ready hit
// or a hazard on an in-flight, not-yet-ready producer.
module fwd_match
  import even_pipe_pkg::*;
#(
  parameter int DEPTH = 7,
  parameter int AW    = 7,
  parameter int W     = 128
) (
  input  entry_t [DEPTH:1] ents,
  input  logic             src_valid,
  input  logic [AW-1:0]    src_addr,
  output logic             hit,
  output logic             hazard,
  output logic [W-1:0]     data
);
  logic found;
  logic unused_unit;

  always_comb begin
    hit         = 1'b0;
    hazard      = 1'b0;
    data        = '0;
    found       = 1'b0;
    unused_unit = 1'b0;
    for (int s = 1; s <= DEPTH; s++) begin
      unused_unit = unused_unit ^ (^ents[s].unit);
      // First match wins, so an older ready copy never masks a younger stale one.
      if (!found && src_valid && ents[s].valid && !ents[s].killed &&
          ents[s].write && ents[s].addr == src_addr) begin
        found  = 1'b1;
        hit    = ents[s].ready;
        hazard = !ents[s].ready;
        data   = ents[s].ready ? ents[s].data : '0;
      end
    end
  end
endmodule

// File: rtl/even_result_pipe.sv
// Result-staging shift pipe: captures unit results at their completion stage,
// forwards ready values, stalls on unready producers, single writeback port.
module even_result_pipe
  import even_pipe_pkg::*;
#(
  parameter int                     W           = 128,
  parameter int                     AW          = 7,
  parameter int                     NUM_UNITS   = 4,
  parameter logic [NUM_UNITS*4-1:0] LAT         = {4'd6, 4'd4, 4'd4, 4'd2},
  parameter int                     DEPTH       = 7,
  parameter int                     NSRC        = 3,
  parameter int                     FLUSH_DEPTH = 2
) (
  input logic               clk,
  input logic               reset,
  even_result_pipe_if.slave bus
);
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_lat_chk
    if (lat_of(64'(LAT), u, NUM_UNITS) < 1 || lat_of(64'(LAT), u, NUM_UNITS) >= DEPTH) begin : g_bad
      $error("even_result_pipe: unit latency out of range 1..DEPTH-1");
    end
  end
  if (W != PKG_W || AW != PKG_AW || NUM_UNITS > 4) begin : g_bad_cfg
    $error("even_result_pipe: W/AW/NUM_UNITS do not fit entry_t");
  end

  entry_t [DEPTH:1]        pipe_q, pipe_d;
  logic                    err_orphan_q, err_orphan_d;
  logic                    err_missing_q, err_missing_d;
  logic [31:0]             stall_cnt_q, stall_cnt_d;
  logic [NSRC-1:0]         hit, hazard;
  logic [NSRC-1:0][W-1:0]  fdata;
  logic                    stall, issue_ok, miss_now, wb_fire;
  int                      lat;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_match #(.DEPTH(DEPTH), .AW(AW), .W(W)) u_fm (
      .ents     (pipe_q),
      .src_valid(bus.src_valid[i]),
      .src_addr (bus.src_addr[i]),
      .hit      (hit[i]),
      .hazard   (hazard[i]),
      .data     (fdata[i])
    );
  end

  always_comb begin
    stall         = bus.iss_valid & (|hazard);
    issue_ok      = bus.iss_valid & ~stall & ~bus.flush;
    pipe_d        = '0;
    err_orphan_d  = err_orphan_q;
    lat           = 0;
    if (issue_ok) begin
      pipe_d[1].valid = 1'b1;
      pipe_d[1].write = bus.iss_reg_write;
      pipe_d[1].unit  = unit_e'(bus.iss_unit);
      pipe_d[1].addr  = bus.iss_rt_addr;
    end
    for (int s = 2; s <= DEPTH; s++) begin
      pipe_d[s] = pipe_q[s-1];
      if (bus.flush && (s - 1) <= FLUSH_DEPTH) pipe_d[s].killed = 1'b1;
    end
    // Killed entries still take their result so it is not reported as orphaned.
    for (int u = 0; u < NUM_UNITS; u++) begin
      lat = int'(lat_of(64'(LAT), u, NUM_UNITS));
      if (bus.res_valid[u]) begin
        if (pipe_q[lat].valid && int'(pipe_q[lat].unit) == u) begin
          pipe_d[lat+1].ready = 1'b1;
          pipe_d[lat+1].data  = bus.res_data[u];
        end else begin
          err_orphan_d = 1'b1;
        end
      end
    end
    miss_now      = pipe_q[DEPTH].valid & ~pipe_q[DEPTH].killed & ~pipe_q[DEPTH].ready;
    wb_fire       = pipe_q[DEPTH].valid & ~pipe_q[DEPTH].killed & pipe_q[DEPTH].write &
                    pipe_q[DEPTH].ready;
    err_missing_d = err_missing_q | miss_now;
    stall_cnt_d   = (stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q        <= '0;
      err_orphan_q  <= 1'b0;
      err_missing_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      pipe_q        <= pipe_d;
      err_orphan_q  <= err_orphan_d;
      err_missing_q <= err_missing_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.fwd_hit     = hit;
  assign bus.fwd_data    = fdata;
  assign bus.wb_valid    = wb_fire;
  assign bus.wb_addr     = wb_fire ? pipe_q[DEPTH].addr : '0;
  assign bus.wb_data     = wb_fire ? pipe_q[DEPTH].data : '0;
  assign bus.err_orphan  = err_orphan_q;
  assign bus.err_missing = err_missing_q | miss_now;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: doc/even_result_pipe.md
Name: even_result_pipe

Overview:
- Parametrised result-staging, forwarding and RAW-stall block for an execution pipe.
- Serves NUM_UNITS execution units with independent fixed latencies.
- Tracks every issued instruction in a shift pipe of DEPTH stages, captures unit results at each unit's completion stage, forwards ready values to NSRC source operands and stalls issue on not-yet-ready producers.
- Supports branch flush of young entries and drives one register-file writeback port.

Parameters:
- W, 128: data width.
- AW, 7: register address width.
- NUM_UNITS, 4: number of execution units.
- LAT, {4'd6,4'd4,4'd4,4'd2}: packed 4-bit latency per unit; unit u uses LAT[u]. Each value must lie in 1..DEPTH-1; elaboration error otherwise.
- DEPTH, 7: writeback stage index.
- NSRC, 3: source operands checked per cycle.
- FLUSH_DEPTH, 2: stages 1..FLUSH_DEPTH are killed on flush.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- iss_valid, in, 1: instruction issue request.
- iss_unit, in, $clog2(NUM_UNITS): target unit.
- iss_rt_addr, in, AW: destination register.
- iss_reg_write, in, 1: instruction writes the register file.
- src_valid, in, NSRC: source operand i is used.
- src_addr, in, NSRC*AW: source register addresses.
- res_valid, in, NUM_UNITS: unit u result present this cycle.
- res_data, in, NUM_UNITS*W: unit results.
- flush, in, 1: branch taken; kill young entries.
- stall, out, 1: RAW hazard; issue is blocked.
- fwd_hit, out, NSRC: forwarded value is valid for source i.
- fwd_data, out, NSRC*W: forwarded values.
- wb_valid, out, 1: register-file write enable.
- wb_addr, out, AW: write address.
- wb_data, out, W: write data.
- err_orphan, out, 1: sticky; a result arrived with no matching live entry.
- err_missing, out, 1: sticky; an entry reached writeback without a result.
- stall_cnt, out, 32: count of stall cycles, saturating.

Behaviour:
- Entry fields: valid, killed, write, unit, addr, ready, data.
- Pipe shift:
  - Stage s holds the instruction issued s cycles ago.
  - Each edge moves stage s to s+1.
  - Stage 1 is loaded from issue when iss_valid & !stall & !flush; otherwise stage 1 gets a bubble (valid=0).
  - Stage DEPTH is discarded after its writeback cycle.
- Result capture:
  - If res_valid[u] is high and stage LAT[u] holds valid & unit==u, set ready=1 and data=res_data[u] as that entry moves to stage LAT[u]+1.
  - Killed entries absorb their result silently.
  - If res_valid[u] is high and no valid entry of unit u sits in stage LAT[u], set err_orphan=1.
  - Multiple units may complete in the same cycle; their stages differ, so there is no conflict.
- Writeback:
  - wb_valid = stage DEPTH valid & !killed & write & ready, decoded from registers with no combinational input path.
  - If stage DEPTH is valid & !killed & !ready, set err_missing=1 and suppress the write.
  - Issue-to-writeback latency is DEPTH cycles.
- Forwarding (combinational), per source i with src_valid[i]:
  - Search stages 1..DEPTH, youngest (lowest s) first, for valid & !killed & write & addr==src_addr[i].
  - Youngest match ready: fwd_hit[i]=1 and fwd_data[i]=its data.
  - Youngest match not ready: fwd_hit[i]=0 and the source raises a hazard.
  - No match: fwd_hit[i]=0 and fwd_data[i]=0.
  - An older ready match never overrides a younger unready one.
- Stall:
  - stall = OR of source hazards, gated by iss_valid.
  - A stalled issue is not recorded; the front end holds the instruction and re-presents it.
  - stall_cnt increments each cycle stall=1 and saturates at 2^32-1.
- Flush:
  - At the edge, entries in stages 1..FLUSH_DEPTH set killed=1.
  - The same-cycle issue is dropped.
  - Killed entries still shift and occupy their slot, never write back and never forward.
- Reset: all entries are cleared to valid=0. stall, fwd_hit, wb_valid, wb_addr, wb_data, err_orphan, err_missing and stall_cnt all read 0. Reset overrides flush and issue.
- Corner cases:
  - Same-address producers in flight: the youngest one is forwarded.
  - A source matching the entry at stage DEPTH forwards normally in its writeback cycle.

Decomposition:
- Package even_pipe_pkg holds:
  - the entry_t struct;
  - the unit_e enum (FP, FX2, BYTE, FX1);
  - localparam helpers for lat_of(u) and the stage-index width.
- Sub-module fwd_match:
  - one instance per source;
  - priority search over the DEPTH entries;
  - outputs hit, hazard and data.

Test Plan:
- Defaults; issue FX1 (unit 3, LAT 2) with rt=5; res_valid[3]=1 with data 0xA5 at cycle 2 → fwd_hit=1 with 0xA5 for src=5 from cycle 3; wb_valid with addr 5 and data 0xA5 at cycle 7.
- Issue FP (LAT 6) rt=9; next cycle present src=9 → stall=1 for cycles 1..6, stall_cnt=6; forward hits at cycle 7.
- Issue FX2 rt=4 (data 0x11), then FX1 rt=4 (data 0x22) one cycle later; both have results and an unrelated issue presents src=4 after both are ready → fwd_data=0x22; both write back in order, 0x11 then 0x22.
- Issue at cycles 0, 1 and 2, then flush at cycle 2 → the cycle-2 issue is dropped, the cycle-1 entry (stage 1) and cycle-0 entry (stage 2) are killed, with no wb and no error; an entry issued at cycle −1 (stage 3) writes back normally.
- res_valid[2]=1 with an empty pipe → err_orphan=1, held until reset. Issue BYTE with no result → err_missing=1 at cycle 7 with wb_valid=0.
- Assert reset mid-stream with 4 live entries → next cycle all outputs are 0, with no writebacks afterwards.
